// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, memory wait, IF/ID register with stall/redirect/halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WAIT  = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam int             CW        = $clog2(MEM_WAIT + 2);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_WAIT);

  typedef enum logic [1:0] {FETCH, READY, HALT} state_t;

  state_t        state, state_next;
  logic [31:0]   pc, pc_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          slot_free, consume, sample;
  logic          do_capture, do_halt, flush;

  assign imem_addr = pc;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cnt;
    do_capture = 1'b0;
    do_halt    = 1'b0;
    flush      = 1'b0;
    sample     = 1'b0;
    slot_free  = !if_id_valid || !stall;
    consume    = if_id_valid && !stall;
    case (state)
      FETCH, READY: begin
        // READY keeps the counter saturated, so it is always at the sample point
        sample = (state == READY) || (cnt == WAIT_LAST);
        if (redirect_valid) begin
          pc_next    = redirect_pc & 32'hFFFF_FFFC;
          cnt_next   = '0;
          state_next = FETCH;
          flush      = 1'b1;
        end else if (sample && slot_free) begin
          if (imem_instr == HALT_WORD) begin
            do_halt    = 1'b1;
            state_next = HALT;
          end else begin
            do_capture = 1'b1;
            pc_next    = pc + 32'd4;
            cnt_next   = '0;
            state_next = FETCH;
          end
        end else if (sample) begin
          state_next = READY;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC & 32'hFFFF_FFFC;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      if (do_capture) begin
        if_id_instr <= imem_instr;
        if_id_pc4   <= pc + 32'd4;
        if_id_valid <= 1'b1;
        instr_count <= instr_count + 32'd1;
      end else if (flush || consume) begin
        if_id_valid <= 1'b0;
      end
      if (do_halt) halted <= 1'b1;
    end
  end

endmodule
